multicycle_ctrl: RTL

//  Main control FSM for the multi-cycle MIPS datapath; sits directly upstream of ALU_Ctrl and drives its ALUOp input.

---
 rtl/ctrl_pkg.sv | 70 +++++++
 rtl/multicycle_ctrl_if.sv | 34 +++
 rtl/ctrl_out_decode.sv | 91 +++++++++
 rtl/multicycle_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main control FSM:
// opcodes, ALUOp codes, mux select codes, state encodings and the control word.
package ctrl_pkg;

    localparam int STATE_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_RTYPE = 3'b110;

    localparam logic [1:0] SRC_B_RT      = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_R_EXEC    = 4'd3,
        ST_R_WB      = 4'd4,
        ST_I_EXEC    = 4'd5,
        ST_I_WB      = 4'd6,
        ST_BRANCH    = 4'd7,
        ST_JUMP      = 4'd8,
        ST_MEM_ADDR  = 4'd9,
        ST_MEM_READ  = 4'd10,
        ST_MEM_WB    = 4'd11,
        ST_MEM_WRITE = 4'd12
    } state_t;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       retire;
        logic       illegal;
    } ctrl_word_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_ADDI, OP_SLTI, OP_BEQ, OP_LW, OP_SW, OP_J: is_legal_op = 1'b1;
            default:                                               is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Handshake between the main control FSM and the datapath/memory it steers.
interface multicycle_ctrl_if;
    logic [5:0] opcode_i;
    logic       mem_ready_i;
    logic [2:0] alu_op_o;
    logic       alu_src_a_o;
    logic [1:0] alu_src_b_o;
    logic       pc_write_o;
    logic       pc_write_cond_o;
    logic [1:0] pc_source_o;
    logic       i_or_d_o;
    logic       mem_read_o;
    logic       mem_write_o;
    logic       ir_write_o;
    logic       reg_dst_o;
    logic       mem_to_reg_o;
    logic       reg_write_o;
    logic       retire_o;
    logic       illegal_o;

    modport master (
        input  opcode_i, mem_ready_i,
        output alu_op_o, alu_src_a_o, alu_src_b_o, pc_write_o, pc_write_cond_o,
               pc_source_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o,
               reg_dst_o, mem_to_reg_o, reg_write_o, retire_o, illegal_o
    );

    modport slave (
        output opcode_i, mem_ready_i,
        input  alu_op_o, alu_src_a_o, alu_src_b_o, pc_write_o, pc_write_cond_o,
               pc_source_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o,
               reg_dst_o, mem_to_reg_o, reg_write_o, retire_o, illegal_o
    );
endinterface

// File: rtl/ctrl_out_decode.sv
// Moore control-word decode of the FSM state; only FETCH write-enables, the
// sw retire and the DECODE illegal flag look at live inputs.
module ctrl_out_decode
    import ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode_lat,
    input  logic [5:0] opcode_live,
    input  logic       mem_ready,
    output ctrl_word_t cw
);

    // Control word selection per state
    always_comb begin
        cw = '0;
        case (state)
            ST_FETCH: begin
                cw.mem_read  = 1'b1;
                cw.alu_src_b = SRC_B_FOUR;
                cw.alu_op    = ALU_ADD;
                cw.pc_source = PC_SRC_ALU;
                cw.ir_write  = mem_ready;
                cw.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                cw.alu_src_b = SRC_B_IMM_SH2;
                cw.alu_op    = ALU_ADD;
                cw.illegal   = ~is_legal_op(opcode_live);
            end
            ST_R_EXEC: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRC_B_RT;
                cw.alu_op    = ALU_RTYPE;
            end
            ST_R_WB: begin
                cw.reg_dst   = 1'b1;
                cw.reg_write = 1'b1;
                cw.retire    = 1'b1;
            end
            ST_I_EXEC: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRC_B_IMM;
                if (opcode_lat == OP_SLTI) begin
                    cw.alu_op = ALU_SLT;
                end else begin
                    cw.alu_op = ALU_ADD;
                end
            end
            ST_I_WB: begin
                cw.reg_write = 1'b1;
                cw.retire    = 1'b1;
            end
            ST_BRANCH: begin
                cw.alu_src_a     = 1'b1;
                cw.alu_src_b     = SRC_B_RT;
                cw.alu_op        = ALU_SUB;
                cw.pc_write_cond = 1'b1;
                cw.pc_source     = PC_SRC_ALUOUT;
                cw.retire        = 1'b1;
            end
            ST_JUMP: begin
                cw.pc_write  = 1'b1;
                cw.pc_source = PC_SRC_JUMP;
                cw.retire    = 1'b1;
            end
            ST_MEM_ADDR: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRC_B_IMM;
                cw.alu_op    = ALU_ADD;
            end
            ST_MEM_READ: begin
                cw.mem_read = 1'b1;
                cw.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                cw.mem_to_reg = 1'b1;
                cw.reg_write  = 1'b1;
                cw.retire     = 1'b1;
            end
            ST_MEM_WRITE: begin
                cw.mem_write = 1'b1;
                cw.i_or_d    = 1'b1;
                cw.retire    = mem_ready;
            end
            default: begin
                cw = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS datapath: state register, opcode
// register and sequencing; the control word comes from ctrl_out_decode.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    multicycle_ctrl_if.master   bus
);

    state_t     state_r;
    state_t     state_next_s;
    logic [5:0] opcode_r;
    ctrl_word_t cw_s;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Opcode captured in DECODE so later states ignore IR changes
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            opcode_r <= 6'b000000;
        end else if (state_r == ST_DECODE) begin
            opcode_r <= bus.opcode_i;
        end else begin
            opcode_r <= opcode_r;
        end
    end

    // Next-state sequencing
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE:  state_next_s = ST_FETCH;
            ST_FETCH: begin
                if (bus.mem_ready_i) begin
                    state_next_s = ST_DECODE;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                case (bus.opcode_i)
                    OP_RTYPE:      state_next_s = ST_R_EXEC;
                    OP_ADDI,
                    OP_SLTI:       state_next_s = ST_I_EXEC;
                    OP_BEQ:        state_next_s = ST_BRANCH;
                    OP_LW, OP_SW:  state_next_s = ST_MEM_ADDR;
                    OP_J:          state_next_s = ST_JUMP;
                    default:       state_next_s = ST_FETCH;
                endcase
            end
            ST_R_EXEC:  state_next_s = ST_R_WB;
            ST_I_EXEC:  state_next_s = ST_I_WB;
            ST_R_WB,
            ST_I_WB,
            ST_BRANCH,
            ST_JUMP,
            ST_MEM_WB:  state_next_s = ST_FETCH;
            ST_MEM_ADDR: begin
                if (opcode_r == OP_LW) begin
                    state_next_s = ST_MEM_READ;
                end else if (opcode_r == OP_SW) begin
                    state_next_s = ST_MEM_WRITE;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_MEM_READ: begin
                if (bus.mem_ready_i) begin
                    state_next_s = ST_MEM_WB;
                end else begin
                    state_next_s = ST_MEM_READ;
                end
            end
            ST_MEM_WRITE: begin
                if (bus.mem_ready_i) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_MEM_WRITE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    ctrl_out_decode u_decode (
        .state       (state_r),
        .opcode_lat  (opcode_r),
        .opcode_live (bus.opcode_i),
        .mem_ready   (bus.mem_ready_i),
        .cw          (cw_s)
    );

    assign bus.alu_op_o        = cw_s.alu_op;
    assign bus.alu_src_a_o     = cw_s.alu_src_a;
    assign bus.alu_src_b_o     = cw_s.alu_src_b;
    assign bus.pc_write_o      = cw_s.pc_write;
    assign bus.pc_write_cond_o = cw_s.pc_write_cond;
    assign bus.pc_source_o     = cw_s.pc_source;
    assign bus.i_or_d_o        = cw_s.i_or_d;
    assign bus.mem_read_o      = cw_s.mem_read;
    assign bus.mem_write_o     = cw_s.mem_write;
    assign bus.ir_write_o      = cw_s.ir_write;
    assign bus.reg_dst_o       = cw_s.reg_dst;
    assign bus.mem_to_reg_o    = cw_s.mem_to_reg;
    assign bus.reg_write_o     = cw_s.reg_write;
    assign bus.retire_o        = cw_s.retire;
    assign bus.illegal_o       = cw_s.illegal;

endmodule
